jawbreak_vend_ctrl: RTL

- Sequencing controller for the jawbreaker vending path.
- Accepts nickel, dime and quarter pulses and accumulates credit in 5-cent units.
- When credit reaches the price, it runs a dispenser handshake, then pays out any remainder as nickels over a change-hopper handshake.
- Also handles a customer refund button and an inactivity timeout; sits between the coin acceptor and the dispenser/hopper drivers.

---
 rtl/jawbreak_vend_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/jawbreak_vend_ctrl.sv
// Jawbreaker vending sequencer: accumulates coin credit in nickels, runs the
// dispenser handshake once the price is met, then pays change one nickel at a time.
module jawbreak_vend_ctrl #(
    parameter int PRICE      = 5,
    parameter int MAX_CREDIT = 15,
    parameter int TIMEOUT    = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       nickel,
    input  logic       dime,
    input  logic       quarter,
    input  logic       refund,
    input  logic       disp_ack,
    input  logic       chg_ack,
    output logic       disp_req,
    output logic       chg_req,
    output logic       coin_reject,
    output logic [3:0] credit,
    output logic       busy
);

    localparam int              TMR_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [4:0]      PRICE_W   = 5'(PRICE);
    localparam logic [3:0]      PRICE_C   = 4'(PRICE);
    localparam logic [4:0]      MAX_W     = 5'(MAX_CREDIT);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ACCUM    = 2'd1,
        S_DISPENSE = 2'd2,
        S_CHANGE   = 2'd3
    } state_t;

    state_t           r_state;
    logic [3:0]       r_credit;
    logic [TMR_W-1:0] r_timer;
    logic             r_disp_req;
    logic             r_chg_req;
    logic             r_busy;
    logic             r_coin_reject;

    logic             w_coin_any;
    logic             w_coin_one;
    logic [2:0]       w_coin_val;
    logic [4:0]       w_sum;
    logic             w_fits;
    logic             w_coin_open;
    logic             w_coin_acc;
    logic             w_coin_rej;
    logic [3:0]       w_disp_rem;

    function automatic logic [2:0] coin_value(input logic n, input logic d, input logic q);
        case ({q, d, n})
            3'b001:  return 3'd1;
            3'b010:  return 3'd2;
            3'b100:  return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [3:0] sat_sub(input logic [3:0] a, input logic [3:0] b);
        return (a > b) ? (a - b) : 4'd0;
    endfunction

    // Coin qualification: exactly one coin, a state that takes coins, no overflow.
    assign w_coin_any  = nickel | dime | quarter;
    assign w_coin_one  = $onehot({quarter, dime, nickel});
    assign w_coin_val  = coin_value(nickel, dime, quarter);
    assign w_sum       = {1'b0, r_credit} + {2'b00, w_coin_val};
    assign w_fits      = (w_sum <= MAX_W);
    assign w_coin_open = (r_state == S_IDLE) || ((r_state == S_ACCUM) && !refund);
    assign w_coin_acc  = w_coin_open && w_coin_one && w_fits;
    assign w_coin_rej  = w_coin_any && !w_coin_acc;
    assign w_disp_rem  = sat_sub(r_credit, PRICE_C);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_credit      <= 4'd0;
            r_timer       <= '0;
            r_disp_req    <= 1'b0;
            r_chg_req     <= 1'b0;
            r_busy        <= 1'b0;
            r_coin_reject <= 1'b0;
        end else begin
            r_coin_reject <= w_coin_rej;
            case (r_state)
                S_IDLE: begin
                    if (w_coin_acc) begin
                        r_credit <= w_sum[3:0];
                        r_timer  <= '0;
                        if (w_sum >= PRICE_W) begin
                            r_state    <= S_DISPENSE;
                            r_disp_req <= 1'b1;
                            r_busy     <= 1'b1;
                        end else begin
                            r_state <= S_ACCUM;
                        end
                    end
                end

                S_ACCUM: begin
                    // Refund wins over a simultaneous coin; that coin is rejected above.
                    if (refund) begin
                        r_state   <= S_CHANGE;
                        r_timer   <= '0;
                        r_chg_req <= 1'b1;
                        r_busy    <= 1'b1;
                    end else if (w_coin_acc) begin
                        r_credit <= w_sum[3:0];
                        r_timer  <= '0;
                        if (w_sum >= PRICE_W) begin
                            r_state    <= S_DISPENSE;
                            r_disp_req <= 1'b1;
                            r_busy     <= 1'b1;
                        end
                    end else if (r_timer == TMR_LAST) begin
                        r_state   <= S_CHANGE;
                        r_timer   <= '0;
                        r_chg_req <= 1'b1;
                        r_busy    <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                S_DISPENSE: begin
                    if (disp_ack) begin
                        r_credit   <= w_disp_rem;
                        r_disp_req <= 1'b0;
                        if (w_disp_rem == 4'd0) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state   <= S_CHANGE;
                            r_chg_req <= 1'b1;
                        end
                    end
                end

                S_CHANGE: begin
                    // Nothing owed means nothing to pay; never underflow the credit.
                    if (r_credit == 4'd0) begin
                        r_state   <= S_IDLE;
                        r_chg_req <= 1'b0;
                        r_busy    <= 1'b0;
                    end else if (chg_ack) begin
                        r_credit <= r_credit - 4'd1;
                        if (r_credit == 4'd1) begin
                            r_state   <= S_IDLE;
                            r_chg_req <= 1'b0;
                            r_busy    <= 1'b0;
                        end
                    end
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_credit   <= 4'd0;
                    r_timer    <= '0;
                    r_disp_req <= 1'b0;
                    r_chg_req  <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign disp_req    = r_disp_req;
    assign chg_req     = r_chg_req;
    assign busy        = r_busy;
    assign coin_reject = r_coin_reject;
    assign credit      = r_credit;

endmodule
